// File: rtl/module_serial_subtractor.sv
// Bit-serial subtractor: computes A - B one bit per clock, LSB first,
// with registered difference, borrow-out and signed overflow.
module module_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_overflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic             armed_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             bin_q;
    logic [CW-1:0]    cnt_q;

    logic a_bit;
    logic b_bit;
    logic d_bit;
    logic bout;
    logic last;
    logic accept;

    assign a_bit  = a_q[0];
    assign b_bit  = b_q[0];
    assign d_bit  = a_bit ^ b_bit ^ bin_q;
    assign bout   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin_q);
    assign last   = (cnt_q == CW'(WIDTH - 1));
    assign accept = (state_q == IDLE) && i_start && armed_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Blocks acceptance on the first edge after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            bin_q      <= 1'b0;
            cnt_q      <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_diff     <= '0;
            o_borrow   <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_busy <= (state_d == RUN);
            o_done <= (state_d == DONE);
            if (accept) begin
                a_q   <= i_minuend;
                b_q   <= i_subtrahend;
                res_q <= '0;
                bin_q <= 1'b0;
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                a_q   <= a_q >> 1;
                b_q   <= b_q >> 1;
                res_q <= {d_bit, res_q[WIDTH-1:1]};
                bin_q <= bout;
                cnt_q <= cnt_q + CW'(1);
                // On the last bit the shift registers hold the operand MSBs.
                if (last) begin
                    o_diff     <= {d_bit, res_q[WIDTH-1:1]};
                    o_borrow   <= bout;
                    o_overflow <= (a_bit != b_bit) && (d_bit != a_bit);
                end
            end
        end
    end

endmodule

// File: tb/tb_module_serial_subtractor.sv
// Self-checking bench for module_serial_subtractor (WIDTH=8):
// directed corner cases plus randomized operations against an arithmetic model.
module tb_module_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;

    int total;
    int passed;
    int cyc;

    module_serial_subtractor #(.WIDTH(W)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_start(start),
        .i_minuend(a_in),
        .i_subtrahend(b_in),
        .o_busy(busy),
        .o_done(done),
        .o_diff(diff),
        .o_borrow(borrow),
        .o_overflow(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] m_diff(input int a, input int b);
        return W'((a - b + 256) % 256);
    endfunction

    function automatic logic m_borrow(input int a, input int b);
        return a < b;
    endfunction

    function automatic logic m_ovf(input int a, input int b);
        int sa;
        int sb;
        int r;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        r  = sa - sb;
        return (r > 127) || (r < -128);
    endfunction

    // Starts at a negedge; returns at the negedge where o_done is seen.
    task automatic do_op(input string tag, input int a, input int b,
                         input bit chk_hold, input logic [W-1:0] hold_val);
        int  lat;
        int  bcnt;
        bit  held;
        start = 1'b1;
        a_in  = W'(a);
        b_in  = W'(b);
        @(negedge clk);
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        lat   = 0;
        bcnt  = 0;
        held  = 1'b1;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            if (diff !== hold_val) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 8);
        check({tag, "_busy_cycles"}, bcnt, 8);
        check({tag, "_diff"}, diff, m_diff(a, b));
        check({tag, "_borrow"}, borrow, m_borrow(a, b));
        check({tag, "_ovf"}, ovf, m_ovf(a, b));
        if (chk_hold) check({tag, "_hold"}, held, 1);
    endtask

    initial begin
        int t_first;
        int n;
        bit no_done;
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        do_op("a05_b03", 'h05, 'h03, 1'b0, '0);
        @(negedge clk);
        check("a05_single_pulse", done, 0);
        do_op("a03_b05", 'h03, 'h05, 1'b0, '0);
        @(negedge clk);
        do_op("a80_b01", 'h80, 'h01, 1'b0, '0);
        @(negedge clk);
        do_op("a7f_bff", 'h7F, 'hFF, 1'b0, '0);
        @(negedge clk);

        // Start request during RUN must be ignored.
        start = 1'b1;
        a_in  = 8'h10;
        b_in  = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ign_done_seen", done, 1);
        check("ign_diff", diff, 8'h0F);
        check("ign_borrow", borrow, 0);
        @(negedge clk);
        do_op("hold", 'h33, 'h11, 1'b1, 8'h0F);
        @(negedge clk);

        // Reset in the middle of RUN.
        start = 1'b1;
        a_in  = 8'h55;
        b_in  = 8'h22;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_diff", diff, 0);
        check("mid_rst_borrow", borrow, 0);
        check("mid_rst_ovf", ovf, 0);
        no_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) no_done = 1'b0;
        end
        check("mid_rst_no_done", no_done, 1);
        rst_n = 1'b1;
        start = 1'b1;
        a_in  = 8'h00;
        b_in  = 8'h00;
        @(negedge clk);
        check("first_edge_no_accept", busy, 0);
        do_op("a00_b00", 'h00, 'h00, 1'b0, '0);
        @(negedge clk);

        // Back-to-back: restart in the IDLE cycle right after DONE.
        do_op("b2b_1", 'hC3, 'h5A, 1'b0, '0);
        t_first = cyc;
        @(negedge clk);
        check("b2b_pulse_end", done, 0);
        do_op("b2b_2", 'h12, 'h34, 1'b0, '0);
        check("b2b_spacing", cyc - t_first, 10);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            do_op("rand", int'($urandom_range(255)),
                  int'($urandom_range(255)), 1'b0, '0);
            repeat (1 + $urandom_range(2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/module_serial_subtractor.md
MODULE_SERIAL_SUBTRACTOR -- requirements
Module: module_serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits, legal range 2 to 32.
REQ-002 SHALL have port i_clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port i_start, input, 1 bit: request to subtract; sampled only in IDLE.
REQ-005 SHALL have port i_minuend, input, WIDTH bits: operand A; captured on start acceptance.
REQ-006 SHALL have port i_subtrahend, input, WIDTH bits: operand B; captured on start acceptance.
REQ-007 SHALL have port o_busy, output, 1 bit: high while in RUN.
REQ-008 SHALL have port o_done, output, 1 bit: single-cycle pulse, results valid.
REQ-009 SHALL have port o_diff, output, WIDTH bits: A minus B modulo 2^WIDTH.
REQ-010 SHALL have port o_borrow, output, 1 bit: final borrow-out, meaning unsigned A < B.
REQ-011 SHALL have port o_overflow, output, 1 bit: two's-complement overflow of A minus B.

Function
REQ-012 SHALL implement a state machine with states IDLE, RUN and DONE, entering IDLE on reset.
REQ-013 SHALL accept a start in IDLE when i_start=1 at edge E0: latch A and B into shift registers, clear borrow flop and bit counter, go to RUN.
REQ-014 SHALL ignore i_start in RUN and DONE: no reload, no effect on the operation in progress.
REQ-015 SHALL process one bit per RUN edge, LSB first: d = a XOR b XOR bin; bout = (NOT a AND b) OR (NOT(a XOR b) AND bin); then shift A, B and the partial result right by one.
REQ-016 SHALL clear the initial borrow-in to 0 at start acceptance.
REQ-017 SHALL process bit k at edge E(k+1) in RUN, for k = 0 to WIDTH-1.
REQ-018 SHALL, at edge E(WIDTH), after processing bit WIDTH-1, transfer to the output registers: o_diff from the partial result, o_borrow from the final bout, and o_overflow = (A[msb] != B[msb]) AND (diff[msb] != A[msb]), using the latched operand MSBs; then go to DONE.
REQ-019 SHALL drive o_done=1 for exactly the one cycle spent in DONE.
REQ-020 SHALL go from DONE to IDLE on the next edge, so o_done lasts exactly one cycle.
REQ-021 SHALL have a latency from start edge E0 to o_done high of WIDTH edges, i.e. o_done is visible in the cycle after E(WIDTH).
REQ-022 SHALL hold o_diff, o_borrow and o_overflow stable from the DONE transfer until the next DONE transfer; they SHALL NOT change during a later RUN.
REQ-023 SHALL accept a new start in the IDLE cycle immediately after DONE, giving a minimum throughput of one operation per WIDTH+2 cycles.
REQ-024 SHALL drive o_busy as a registered decode: 1 exactly in RUN, 0 in IDLE and DONE.
REQ-025 SHALL size the bit counter as ceil(log2(WIDTH))+1 bits and SHALL NOT wrap during an operation.
REQ-026 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, while i_rst_n=0, asynchronously force state IDLE and set o_busy=0, o_done=0, o_diff=0, o_borrow=0, o_overflow=0, and clear all internal registers.
REQ-028 SHALL, when reset asserts mid-RUN or in DONE, abort the operation with no o_done pulse and no partial result on o_diff.
REQ-029 SHALL release reset synchronously to i_clk and SHALL NOT accept a start on the first rising edge at which i_rst_n is already high.

Verification (WIDTH=8)
REQ-030 SHALL verify: A=0x05, B=0x03, start pulse -> o_busy high 8 cycles, o_done single pulse 8 edges after start, o_diff=0x02, o_borrow=0, o_overflow=0.
REQ-031 SHALL verify: A=0x03, B=0x05 -> o_diff=0xFE, o_borrow=1, o_overflow=0.
REQ-032 SHALL verify: A=0x80, B=0x01 -> o_diff=0x7F, o_borrow=0, o_overflow=1; and A=0x7F, B=0xFF -> o_diff=0x80, o_borrow=1, o_overflow=1.
REQ-033 SHALL verify: start with A=0x10, B=0x01, then i_start=1 with A=0xFF, B=0xFF at RUN cycle 3 -> ignored, o_diff=0x0F; o_diff stays 0x0F through a following operation until its DONE.
REQ-034 SHALL verify: i_rst_n pulsed low at RUN cycle 4 -> all outputs 0 immediately, no o_done; a fresh start of A=0x00, B=0x00 afterwards gives o_diff=0x00, o_borrow=0.
REQ-035 SHALL verify back-to-back operation: start re-asserted in the IDLE cycle after o_done -> accepted, second o_done exactly 10 cycles after the first.
